// File: rtl/piezo_pkg.sv
// Shared types and tune tables for the piezo tune scheduler.
// Periods and durations are in 50 MHz clocks.
package piezo_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_NEXT} state_t;

  typedef enum logic [1:0] {
    TUNE_CHARGE = 2'd0,
    TUNE_DONE   = 2'd1,
    TUNE_ERROR  = 2'd2
  } tune_t;

  localparam int unsigned PER_W = 17;
  localparam int unsigned DUR_W = 25;
  localparam int unsigned IDX_W = 3;

  localparam logic [PER_W-1:0] PER_G6   = 17'd31888;
  localparam logic [PER_W-1:0] PER_C7   = 17'd23889;
  localparam logic [PER_W-1:0] PER_E7   = 17'd18961;
  localparam logic [PER_W-1:0] PER_G7   = 17'd15944;
  localparam logic [PER_W-1:0] PER_A4   = 17'd113636;
  localparam logic [PER_W-1:0] PER_REST = 17'd0;

  localparam logic [DUR_W-1:0] DUR_4M  = 25'd4194304;
  localparam logic [DUR_W-1:0] DUR_8M  = 25'd8388608;
  localparam logic [DUR_W-1:0] DUR_12M = 25'd12582912;
  localparam logic [DUR_W-1:0] DUR_16M = 25'd16777216;

  localparam logic [IDX_W-1:0] NOTES_CHARGE = 3'd6;
  localparam logic [IDX_W-1:0] NOTES_DONE   = 3'd2;
  localparam logic [IDX_W-1:0] NOTES_ERROR  = 3'd3;

  typedef struct packed {
    logic [PER_W-1:0] period;
    logic [DUR_W-1:0] dur;
  } note_t;

  function automatic note_t note_lookup(input tune_t tune, input logic [IDX_W-1:0] idx);
    note_t n;
    n = '{period: PER_REST, dur: DUR_4M};
    case (tune)
      TUNE_CHARGE: begin
        case (idx)
          3'd0:    n = '{period: PER_G6, dur: DUR_8M};
          3'd1:    n = '{period: PER_C7, dur: DUR_8M};
          3'd2:    n = '{period: PER_E7, dur: DUR_8M};
          3'd3:    n = '{period: PER_G7, dur: DUR_12M};
          3'd4:    n = '{period: PER_E7, dur: DUR_4M};
          default: n = '{period: PER_G7, dur: DUR_16M};
        endcase
      end
      TUNE_DONE: begin
        case (idx)
          3'd0:    n = '{period: PER_E7, dur: DUR_4M};
          default: n = '{period: PER_G7, dur: DUR_8M};
        endcase
      end
      TUNE_ERROR: begin
        case (idx)
          3'd1:    n = '{period: PER_REST, dur: DUR_4M};
          default: n = '{period: PER_A4, dur: DUR_4M};
        endcase
      end
      default: n = '{period: PER_REST, dur: DUR_4M};
    endcase
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] note_count(input tune_t tune);
    case (tune)
      TUNE_CHARGE: return NOTES_CHARGE;
      TUNE_DONE:   return NOTES_DONE;
      TUNE_ERROR:  return NOTES_ERROR;
      default:     return IDX_W'(1);
    endcase
  endfunction

  // Fixed priority: error (bit 2) over done (bit 1) over charge (bit 0).
  function automatic logic [2:0] pick_highest(input logic [2:0] v);
    if (v[2])      return 3'b100;
    else if (v[1]) return 3'b010;
    else if (v[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  function automatic logic [2:0] above_mask(input logic [2:0] act);
    if (act[0])      return 3'b110;
    else if (act[1]) return 3'b100;
    else             return 3'b000;
  endfunction

  function automatic tune_t tune_of(input logic [2:0] onehot);
    if (onehot[2])      return TUNE_ERROR;
    else if (onehot[1]) return TUNE_DONE;
    else                return TUNE_CHARGE;
  endfunction

endpackage

// File: rtl/piezo_sched_tone.sv
// Period counter and square-wave generator; period 0 is a rest (output held low).
module piezo_tone
  import piezo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [PER_W-1:0] period_in,
  output logic             piezo
);

  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] cnt_nxt;
  logic [PER_W-1:0] per;
  logic             piezo_d;

  // start is the cycle before the first PLAY cycle, so the level for count 0
  // is registered together with the new period.
  always_comb begin
    per     = start ? period_in : period_q;
    cnt_nxt = '0;
    if (run && !start) begin
      cnt_nxt = ((cnt + PER_W'(1)) >= period_q) ? '0 : cnt + PER_W'(1);
    end
    piezo_d = (start || run) && (per != '0) && (cnt_nxt < (per >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      cnt      <= '0;
      piezo    <= 1'b0;
    end else begin
      if (start) period_q <= period_in;
      cnt   <= cnt_nxt;
      piezo <= piezo_d;
    end
  end

endmodule

// File: rtl/piezo_sched.sv
// Piezo tune scheduler: request latching, priority arbiter, note FSM, duration counter.
// Define PIEZO_PREEMPT_EN to let a higher-priority request abort a playing tune.
module piezo_sched
  import piezo_pkg::*;
#(
  parameter int unsigned FAST_SIM   = 0,
  parameter int unsigned TIME_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] active,
  output logic       tune_done,
  output logic       piezo,
  output logic       piezo_n
);

  localparam logic [DUR_W-1:0] DUR_STEP = (FAST_SIM != 0) ? DUR_W'(16) : DUR_W'(1);

  state_t           state;
  tune_t            tune;
  logic [IDX_W-1:0] idx;
  logic [2:0]       pending;
  logic [DUR_W-1:0] dur_cnt;
  logic [DUR_W-1:0] dur_q;

  logic [2:0]       req_eff;
  logic [2:0]       grant;
  note_t            note;
  logic [PER_W-1:0] fetch_per;
  logic [DUR_W-1:0] fetch_dur;
  logic [DUR_W-1:0] dur_sum;
  logic             note_end;
  logic             last_note;
  logic             preempt;
  logic             tone_start;
  logic             tone_run;

  always_comb begin
    req_eff   = pending | (req & ~active);
    grant     = pick_highest(req_eff);
    note      = note_lookup(tune, idx);
    fetch_per = note.period >> TIME_SHIFT;
    fetch_dur = note.dur >> TIME_SHIFT;
    dur_sum   = dur_cnt + DUR_STEP;
    note_end  = (dur_sum >= dur_q);
    last_note = (idx == (note_count(tune) - IDX_W'(1)));
`ifdef PIEZO_PREEMPT_EN
    preempt   = (state == S_PLAY) && ((req_eff & above_mask(active)) != '0);
`else
    preempt   = 1'b0;
`endif
    tone_start = (state == S_LOAD);
    tone_run   = (state == S_PLAY) && !note_end && !preempt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tune      <= TUNE_CHARGE;
      idx       <= '0;
      pending   <= '0;
      active    <= '0;
      tune_done <= 1'b0;
      dur_cnt   <= '0;
      dur_q     <= '0;
    end else begin
      tune_done <= 1'b0;
      pending   <= req_eff;
      case (state)
        S_IDLE: begin
          if (req_eff != '0) begin
            pending <= req_eff & ~grant;
            active  <= grant;
            tune    <= tune_of(grant);
            idx     <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          dur_q   <= fetch_dur;
          dur_cnt <= '0;
          state   <= S_PLAY;
        end
        S_PLAY: begin
          // An aborted tune is dropped, not re-queued.
          if (preempt) begin
            pending <= req_eff & ~grant;
            active  <= grant;
            tune    <= tune_of(grant);
            idx     <= '0;
            dur_cnt <= '0;
            state   <= S_LOAD;
          end else if (note_end) begin
            dur_cnt <= '0;
            state   <= S_NEXT;
          end else begin
            dur_cnt <= dur_sum;
          end
        end
        S_NEXT: begin
          if (last_note) begin
            tune_done <= 1'b1;
            active    <= '0;
            idx       <= '0;
            state     <= S_IDLE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  piezo_tone u_tone (
    .clk       (clk),
    .rst       (rst),
    .start     (tone_start),
    .run       (tone_run),
    .period_in (fetch_per),
    .piezo     (piezo)
  );

  assign piezo_n = ~piezo;

endmodule
